// File: rtl/sensor_conditioner.sv
// ---------------------------------------------------------------------------
// sensor_conditioner
//
// Front end of the smart lighting path. Turns the raw PIR, ambient-light ADC
// and push-button inputs into clean, registered control inputs for the
// lighting FSM:
//   * every *_raw input passes through a 2-flop synchroniser and a
//     stable-count debouncer;
//   * debounced motion is stretched by an occupancy hold timer
//     (IDLE / ACTIVE / HOLD state machine);
//   * the ambient light sample is classified with hysteresis (DARK_TH /
//     BRIGHT_TH) and light_level only toggles after PERSIST consecutive
//     disagreeing samples;
//   * debounced button presses become single-cycle pulses, with manual_off
//     taking priority over manual_on when both land on the same cycle.
//
// Ports
//   clk          in   1      system clock
//   reset        in   1      asynchronous, active-high reset
//   motion_raw   in   1      PIR output, asynchronous
//   btn_on_raw   in   1      manual-on push button, asynchronous, high = pressed
//   btn_off_raw  in   1      manual-off push button, asynchronous, high = pressed
//   adc_valid    in   1      adc_data qualifier, one cycle per sample
//   adc_data     in   ADC_W  ambient light sample, unsigned
//   motion       out  1      conditioned, stretched occupancy
//   light_level  out  1      1 = night, 0 = day
//   manual_on    out  1      one-cycle pulse per debounced press
//   manual_off   out  1      one-cycle pulse per debounced press
//
// Optional build macro SENSOR_COND_STATUS_EN adds:
//   dbg_state    out  2      registered copy of the motion state
//                            (IDLE = 0, ACTIVE = 1, HOLD = 2)
//   dbg_hold_cnt out  $clog2(HOLD_CYCLES+1)  registered copy of the hold counter
// With the macro undefined those ports and their logic are absent and the
// functional behaviour is identical.
// ---------------------------------------------------------------------------
module sensor_conditioner #(
   parameter int unsigned ADC_W       = 10,
   parameter int unsigned DARK_TH     = 300,
   parameter int unsigned BRIGHT_TH   = 400,
   parameter int unsigned DEB_CYCLES  = 16,
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter int unsigned PERSIST     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             motion_raw,
   input  logic             btn_on_raw,
   input  logic             btn_off_raw,
   input  logic             adc_valid,
   input  logic [ADC_W-1:0] adc_data,
   output logic             motion,
   output logic             light_level,
   output logic             manual_on,
   output logic             manual_off
`ifdef SENSOR_COND_STATUS_EN
   ,
   output logic [1:0]                         dbg_state,
   output logic [$clog2(HOLD_CYCLES+1)-1:0]   dbg_hold_cnt
`endif
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int unsigned NCH    = 3;   // 0 = motion, 1 = btn_on, 2 = btn_off
   localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned PER_W  = $clog2(PERSIST + 1);

   // Counters stop one short of the target: reaching the target and acting on
   // it happen on the same edge, so the counter never has to hold N itself.
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERSIST - 1);

   localparam logic [ADC_W-1:0]  DARK_LVL   = ADC_W'(DARK_TH);
   localparam logic [ADC_W-1:0]  BRIGHT_LVL = ADC_W'(BRIGHT_TH);

   localparam int unsigned CH_MOTION  = 0;
   localparam int unsigned CH_BTN_ON  = 1;
   localparam int unsigned CH_BTN_OFF = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Synchronisers (two flops per asynchronous input)
   // ------------------------------------------------------------------
   logic [NCH-1:0] raw_vec;
   logic [NCH-1:0] sync1_q, sync1_d;
   logic [NCH-1:0] sync2_q, sync2_d;

   assign raw_vec = {btn_off_raw, btn_on_raw, motion_raw};

   always_comb begin
      sync1_d = raw_vec;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   // ------------------------------------------------------------------
   // Debouncers, one per channel.
   // The counter runs while the synchronised input disagrees with the
   // accepted level and restarts whenever they agree, so any excursion
   // shorter than DEB_CYCLES cycles is discarded.
   // ------------------------------------------------------------------
   logic [NCH-1:0] deb_lvl;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_q, cnt_d;
      logic             lvl_q, lvl_d;

      always_comb begin
         cnt_d = '0;
         lvl_d = lvl_q;
         if (sync2_q[gi] != lvl_q) begin
            if (cnt_q == DEB_LAST) begin
               lvl_d = sync2_q[gi];
            end else begin
               cnt_d = cnt_q + DEB_W'(1);
            end
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
         end
      end

      assign deb_lvl[gi] = lvl_q;
   end

   // ------------------------------------------------------------------
   // Motion occupancy FSM with hold timer.
   // The FSM works on debounced levels: IDLE and HOLD are only ever
   // occupied while the debounced input is low, so seeing it high there
   // is exactly a debounced rise (and likewise a low in ACTIVE is a fall).
   // ------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              motion_q, motion_d;
   logic              deb_motion;

   assign deb_motion = deb_lvl[CH_MOTION];

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (deb_motion) begin
               state_d = ST_ACTIVE;
            end
         end

         ST_ACTIVE: begin
            if (!deb_motion) begin
               state_d    = ST_HOLD;
               hold_cnt_d = HOLD_LAST;
            end
         end

         ST_HOLD: begin
            // A retrigger wins over expiry so occupancy never blinks off.
            if (deb_motion) begin
               state_d    = ST_ACTIVE;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end

         default: begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
         end
      endcase

      // Registered output follows the next state so it changes on the same
      // edge as the state register.
      motion_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         motion_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         motion_q   <= motion_d;
      end
   end

   // ------------------------------------------------------------------
   // Ambient light: hysteresis band plus persistence filter.
   // Samples inside [DARK_TH, BRIGHT_TH] vote for the current level, which
   // is what provides the hysteresis.
   // ------------------------------------------------------------------
   logic             light_q, light_d;
   logic [PER_W-1:0] persist_cnt_q, persist_cnt_d;
   logic             cand;

   always_comb begin
      if (adc_data < DARK_LVL) begin
         cand = 1'b1;
      end else if (adc_data > BRIGHT_LVL) begin
         cand = 1'b0;
      end else begin
         cand = light_q;
      end
   end

   always_comb begin
      light_d       = light_q;
      persist_cnt_d = persist_cnt_q;
      if (adc_valid) begin
         if (cand != light_q) begin
            if (persist_cnt_q == PER_LAST) begin
               light_d       = ~light_q;
               persist_cnt_d = '0;
            end else begin
               persist_cnt_d = persist_cnt_q + PER_W'(1);
            end
         end else begin
            persist_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         light_q       <= 1'b0;
         persist_cnt_q <= '0;
      end else begin
         light_q       <= light_d;
         persist_cnt_q <= persist_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Button press pulses. Only the debounced rising edge is reported;
   // a simultaneous off press suppresses the on pulse.
   // ------------------------------------------------------------------
   logic [1:0] btn_prev_q, btn_prev_d;
   logic [1:0] btn_rise;
   logic       manual_on_q, manual_on_d;
   logic       manual_off_q, manual_off_d;

   always_comb begin
      btn_prev_d   = {deb_lvl[CH_BTN_OFF], deb_lvl[CH_BTN_ON]};
      btn_rise     = btn_prev_d & ~btn_prev_q;
      manual_off_d = btn_rise[1];
      manual_on_d  = btn_rise[0] & ~btn_rise[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_prev_q   <= '0;
         manual_on_q  <= 1'b0;
         manual_off_q <= 1'b0;
      end else begin
         btn_prev_q   <= btn_prev_d;
         manual_on_q  <= manual_on_d;
         manual_off_q <= manual_off_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign motion      = motion_q;
   assign light_level = light_q;
   assign manual_on   = manual_on_q;
   assign manual_off  = manual_off_q;

`ifdef SENSOR_COND_STATUS_EN
   // Status copies are loaded from the next-state values so they track
   // state_q / hold_cnt_q exactly, from separate flops.
   logic [1:0]        dbg_state_q, dbg_state_d;
   logic [HOLD_W-1:0] dbg_hold_cnt_q, dbg_hold_cnt_d;

   always_comb begin
      dbg_state_d    = state_d;
      dbg_hold_cnt_d = hold_cnt_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dbg_state_q    <= 2'd0;
         dbg_hold_cnt_q <= '0;
      end else begin
         dbg_state_q    <= dbg_state_d;
         dbg_hold_cnt_q <= dbg_hold_cnt_d;
      end
   end

   assign dbg_state    = dbg_state_q;
   assign dbg_hold_cnt = dbg_hold_cnt_q;
`endif

endmodule
